// File: rtl/sd_block_ctrl_pkg.sv
// Shared definitions for the SD block job sequencer: command indices,
// error codes and the sequencer state encoding.
package sd_block_ctrl_pkg;

  localparam logic [5:0] CMD17 = 6'd17;  // READ_SINGLE_BLOCK
  localparam logic [5:0] CMD24 = 6'd24;  // WRITE_BLOCK

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_CMD  = 2'd1,
    ERR_CRC  = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_WAIT_CMD,
    S_RD_WAIT_DAT,
    S_PROC,
    S_WR_CMD,
    S_WR_WAIT_CMD,
    S_WR_DAT,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/sd_block_ctrl.sv
// Sequences a job of N consecutive 512-byte SD blocks: read, process, write
// back, with per-block retries, a per-phase watchdog and job status.
module sd_block_ctrl
  import sd_block_ctrl_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int TMO_W     = 20
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [31:0] iaddr,
  input  logic [15:0] inblk,
  output logic        ocmd_start,
  output logic [5:0]  ocmd_idx,
  output logic [31:0] ocmd_arg,
  input  logic        icmd_done,
  input  logic        icmd_fail,
  output logic        od_start,
  input  logic        id_done,
  input  logic        id_crc_fail,
  output logic        oproc_start,
  input  logic        iproc_done,
  output logic        obusy,
  output logic        odone,
  output logic        oerror,
  output logic [1:0]  oerr_code,
  output logic [15:0] oblk_cnt
);

  localparam logic [2:0] LAST_TRY = 3'(MAX_RETRY - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q;
  logic [15:0]      nblk_q, blk_cnt_q;
  logic [2:0]       retry_q;
  logic [TMO_W-1:0] wdog_q;
  logic             err_q;
  err_code_e        err_code_q;

  logic             fault, restart_wr, abort, wdog_full, entry_cycle, wdog_run;
  err_code_e        fault_code;

  assign wdog_full   = (wdog_q == '1);
  // The D driver drops a stale done/CRC level only once it sees od_start, which
  // is visible during a data state's first cycle, so that cycle is ignored.
  assign entry_cycle = (wdog_q == '0);
  assign wdog_run    = state_q inside {S_RD_WAIT_CMD, S_RD_WAIT_DAT, S_PROC,
                                       S_WR_WAIT_CMD, S_WR_DAT};

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fault      = 1'b0;
    fault_code = ERR_NONE;
    restart_wr = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      S_IDLE:        if (istart) state_d = (inblk == 16'd0) ? S_FIN : S_RD_CMD;
      S_RD_CMD:      state_d = S_RD_WAIT_CMD;
      S_RD_WAIT_CMD: begin
        if (icmd_fail)      begin fault = 1'b1; fault_code = ERR_CMD; end
        else if (icmd_done) state_d = S_RD_WAIT_DAT;
        else if (wdog_full) begin fault = 1'b1; fault_code = ERR_TMO; end
      end
      S_RD_WAIT_DAT: begin
        if (id_crc_fail && !entry_cycle)  begin fault = 1'b1; fault_code = ERR_CRC; end
        else if (id_done && !entry_cycle) state_d = S_PROC;
        else if (wdog_full)               begin fault = 1'b1; fault_code = ERR_TMO; end
      end
      S_PROC: begin
        if (iproc_done)     state_d = S_WR_CMD;
        else if (wdog_full) begin fault = 1'b1; fault_code = ERR_TMO; end
      end
      S_WR_CMD:      state_d = S_WR_WAIT_CMD;
      S_WR_WAIT_CMD: begin
        restart_wr = 1'b1;
        if (icmd_fail)      begin fault = 1'b1; fault_code = ERR_CMD; end
        else if (icmd_done) state_d = S_WR_DAT;
        else if (wdog_full) begin fault = 1'b1; fault_code = ERR_TMO; end
      end
      S_WR_DAT: begin
        restart_wr = 1'b1;
        if (id_done && !entry_cycle) state_d = S_NEXT;
        else if (wdog_full)          begin fault = 1'b1; fault_code = ERR_TMO; end
      end
      S_NEXT:        state_d = (blk_cnt_q + 16'd1 == nblk_q) ? S_FIN : S_RD_CMD;
      S_FIN:         state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
    if (fault) begin
      if (retry_q < LAST_TRY) state_d = restart_wr ? S_WR_CMD : S_RD_CMD;
      else begin
        abort   = 1'b1;
        state_d = S_FIN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nblk_q      <= '0;
      blk_cnt_q   <= '0;
      retry_q     <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ocmd_start  <= 1'b0;
      ocmd_idx    <= '0;
      ocmd_arg    <= '0;
      od_start    <= 1'b0;
      oproc_start <= 1'b0;
      odone       <= 1'b0;
      obusy       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wdog_q <= '0;
      else if (wdog_run)      wdog_q <= wdog_q + 1'b1;

      if (state_q == S_IDLE && istart) begin
        addr_q     <= iaddr;
        nblk_q     <= inblk;
        blk_cnt_q  <= '0;
        retry_q    <= '0;
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      if (fault && !abort) retry_q <= retry_q + 3'd1;
      if (abort) begin
        err_q      <= 1'b1;
        err_code_q <= fault_code;
      end
      if (state_q == S_NEXT) begin
        addr_q    <= addr_q + 32'd1;
        blk_cnt_q <= blk_cnt_q + 16'd1;
        retry_q   <= '0;
      end

      // Outputs are registered; each reflects the state held in the prior cycle.
      ocmd_start <= (state_q == S_RD_CMD) || (state_q == S_WR_CMD);
      if (state_q == S_RD_CMD || state_q == S_WR_CMD) begin
        ocmd_idx <= (state_q == S_RD_CMD) ? CMD17 : CMD24;
        ocmd_arg <= addr_q;
      end
      od_start    <= (state_q == S_RD_CMD) ||
                     (state_q == S_WR_WAIT_CMD && state_d == S_WR_DAT);
      oproc_start <= (state_q != S_PROC) && (state_d == S_PROC);
      odone       <= (state_q == S_FIN);
      obusy       <= (state_q != S_IDLE);
    end
  end

  assign oerror    = err_q;
  assign oerr_code = err_code_q;
  assign oblk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_sd_block_ctrl.sv
// Directed self-checking bench for sd_block_ctrl with simple behavioural
// CMD, D-line and processing engines.
module tb_sd_block_ctrl;

  logic        iclk = 1'b0;
  logic        irst, istart;
  logic [31:0] iaddr;
  logic [15:0] inblk;
  logic        ocmd_start, od_start, oproc_start, obusy, odone, oerror;
  logic [5:0]  ocmd_idx;
  logic [31:0] ocmd_arg;
  logic        icmd_done, icmd_fail, id_done, id_crc_fail, iproc_done;
  logic [1:0]  oerr_code;
  logic [15:0] oblk_cnt;

  sd_block_ctrl #(.MAX_RETRY(3), .TMO_W(4)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iaddr(iaddr), .inblk(inblk),
    .ocmd_start(ocmd_start), .ocmd_idx(ocmd_idx), .ocmd_arg(ocmd_arg),
    .icmd_done(icmd_done), .icmd_fail(icmd_fail),
    .od_start(od_start), .id_done(id_done), .id_crc_fail(id_crc_fail),
    .oproc_start(oproc_start), .iproc_done(iproc_done),
    .obusy(obusy), .odone(odone), .oerror(oerror), .oerr_code(oerr_code),
    .oblk_cnt(oblk_cnt)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Engine model state and observation log
  logic [5:0]  log_idx[$];
  logic [31:0] log_arg[$];
  logic        log_od[$];
  int  cmd_cnt, dat_cnt, proc_cnt;
  bit  is_rd, dat_rd, proc_hang, wr_dat_seen;
  int  crc_fail_left, rd_cmds, wr_cmds, proc_starts, done_cnt, first_cmd_cyc, start_cyc;
  logic        cap_err, cap_busy;
  logic [1:0]  cap_code;
  logic [15:0] cap_blk;

  initial begin
    cmd_cnt = 0; dat_cnt = 0; proc_cnt = 0; done_cnt = 0;
    crc_fail_left = 0; proc_hang = 0;
    icmd_done = 0; icmd_fail = 0; id_done = 0; id_crc_fail = 0; iproc_done = 0;
    forever begin
      @(negedge iclk);
      icmd_done  = 1'b0;
      iproc_done = 1'b0;
      if (irst) begin
        cmd_cnt = 0; dat_cnt = 0; proc_cnt = 0;
        id_done = 1'b0; id_crc_fail = 1'b0;
      end else begin
        if (ocmd_start) begin
          if (log_idx.size() == 0) first_cmd_cyc = cyc;
          log_idx.push_back(ocmd_idx);
          log_arg.push_back(ocmd_arg);
          log_od.push_back(od_start);
          is_rd = (ocmd_idx == 6'd17);
          if (is_rd) rd_cmds++; else wr_cmds++;
          cmd_cnt = 2;
        end else if (cmd_cnt > 0) begin
          cmd_cnt--;
          if (cmd_cnt == 0) icmd_done = 1'b1;
        end
        if (od_start) begin
          id_done = 1'b0; id_crc_fail = 1'b0;
          dat_rd  = is_rd;
          if (!is_rd) wr_dat_seen = 1'b1;
          dat_cnt = 3;
        end else if (dat_cnt > 0) begin
          dat_cnt--;
          if (dat_cnt == 0) begin
            if (dat_rd && crc_fail_left > 0) begin
              id_crc_fail = 1'b1;
              crc_fail_left--;
            end else id_done = 1'b1;
          end
        end
        if (oproc_start) begin
          proc_starts++;
          proc_cnt = 2;
        end else if (proc_cnt > 0) begin
          proc_cnt--;
          if (proc_cnt == 0 && !proc_hang) iproc_done = 1'b1;
        end
      end
      if (odone) begin
        done_cnt++;
        cap_err = oerror; cap_code = oerr_code; cap_blk = oblk_cnt; cap_busy = obusy;
      end
    end
  end

  task automatic step();
    @(negedge iclk);
    #1;
  endtask

  task automatic clear_log();
    log_idx.delete(); log_arg.delete(); log_od.delete();
    rd_cmds = 0; wr_cmds = 0; proc_starts = 0; wr_dat_seen = 0; first_cmd_cyc = -1;
  endtask

  task automatic start_job(input logic [31:0] a, input logic [15:0] n);
    clear_log();
    step();
    iaddr = a; inblk = n; istart = 1'b1; start_cyc = cyc;
    step();
    istart = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [31:0] a, input logic [15:0] n);
    int  d0;
    bit  seen;
    d0 = done_cnt;
    start_job(a, n);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      seen = (done_cnt != d0);
    end
    check({tag, "_odone_seen"}, seen, 1);
  endtask

  task automatic check_cmd(input string tag, input int i, input logic [5:0] idx,
                           input logic [31:0] arg, input logic od);
    if (i < log_idx.size()) begin
      check($sformatf("%s_cmd%0d_idx", tag, i), log_idx[i], idx);
      check($sformatf("%s_cmd%0d_arg", tag, i), log_arg[i], arg);
      check($sformatf("%s_cmd%0d_dstart", tag, i), log_od[i], od);
    end else check($sformatf("%s_cmd%0d_present", tag, i), 0, 1);
  endtask

  initial begin
    int d0;
    bit seen;
    irst = 1'b1; istart = 1'b0; iaddr = '0; inblk = '0;
    repeat (3) step();
    check("rst_busy", obusy, 0);
    check("rst_done", odone, 0);
    check("rst_error", oerror, 0);
    check("rst_code", oerr_code, 0);
    check("rst_blk", oblk_cnt, 0);
    check("rst_cmd_start", ocmd_start, 0);
    irst = 1'b0;
    step();

    // Single block, ideal engines
    run_job("n1", 32'h100, 16'd1);
    check("n1_latency", first_cmd_cyc - start_cyc, 2);
    check("n1_ncmd", log_idx.size(), 2);
    check_cmd("n1", 0, 6'd17, 32'h100, 1'b1);
    check_cmd("n1", 1, 6'd24, 32'h100, 1'b0);
    check("n1_err", cap_err, 0);
    check("n1_code", cap_code, 0);
    check("n1_blk", cap_blk, 1);
    check("n1_busy_at_done", cap_busy, 1);
    step();
    check("n1_idle_busy", obusy, 0);

    // Three blocks across the 32-bit address wrap
    run_job("n3", 32'hFFFF_FFFF, 16'd3);
    check("n3_ncmd", log_idx.size(), 6);
    check_cmd("n3", 0, 6'd17, 32'hFFFF_FFFF, 1'b1);
    check_cmd("n3", 1, 6'd24, 32'hFFFF_FFFF, 1'b0);
    check_cmd("n3", 2, 6'd17, 32'h0, 1'b1);
    check_cmd("n3", 3, 6'd24, 32'h0, 1'b0);
    check_cmd("n3", 4, 6'd17, 32'h1, 1'b1);
    check_cmd("n3", 5, 6'd24, 32'h1, 1'b0);
    check("n3_blk", cap_blk, 3);
    check("n3_err", cap_err, 0);

    // One CRC failure on the read, then a clean retry
    crc_fail_left = 1;
    run_job("crc1", 32'h55, 16'd1);
    check("crc1_ncmd", log_idx.size(), 3);
    check_cmd("crc1", 0, 6'd17, 32'h55, 1'b1);
    check_cmd("crc1", 1, 6'd17, 32'h55, 1'b1);
    check_cmd("crc1", 2, 6'd24, 32'h55, 1'b0);
    check("crc1_err", cap_err, 0);
    check("crc1_code", cap_code, 0);
    check("crc1_blk", cap_blk, 1);

    // Persistent CRC failure exhausts all attempts
    crc_fail_left = 99;
    run_job("crcx", 32'h200, 16'd2);
    crc_fail_left = 0;
    check("crcx_rd_cmds", rd_cmds, 3);
    check("crcx_wr_cmds", wr_cmds, 0);
    check("crcx_err", cap_err, 1);
    check("crcx_code", cap_code, 2);
    check("crcx_blk", cap_blk, 0);
    step();
    check("crcx_err_sticky", oerror, 1);

    // Processing core never finishes: watchdog timeout on every attempt
    proc_hang = 1;
    run_job("tmo", 32'h300, 16'd1);
    proc_hang = 0;
    check("tmo_rd_cmds", rd_cmds, 3);
    check("tmo_proc_starts", proc_starts, 3);
    check("tmo_wr_cmds", wr_cmds, 0);
    check("tmo_err", cap_err, 1);
    check("tmo_code", cap_code, 3);

    // Zero-length job completes immediately and clears the old error
    run_job("n0", 32'h400, 16'd0);
    check("n0_ncmd", log_idx.size(), 0);
    check("n0_err", cap_err, 0);
    check("n0_code", cap_code, 0);
    check("n0_blk", cap_blk, 0);

    // Reset during the write data phase aborts silently
    start_job(32'h10, 16'd1);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      step();
      seen = wr_dat_seen;
    end
    check("rstmid_wr_dat_reached", seen, 1);
    d0 = done_cnt;
    irst = 1'b1;
    step();
    check("rstmid_busy", obusy, 0);
    check("rstmid_done", odone, 0);
    check("rstmid_cmd_start", ocmd_start, 0);
    check("rstmid_d_start", od_start, 0);
    check("rstmid_proc_start", oproc_start, 0);
    check("rstmid_blk", oblk_cnt, 0);
    check("rstmid_error", oerror, 0);
    irst = 1'b0;
    repeat (6) step();
    check("rstmid_no_odone", done_cnt - d0, 0);
    check("rstmid_still_idle", obusy, 0);

    run_job("after_rst", 32'h20, 16'd2);
    check("after_rst_ncmd", log_idx.size(), 4);
    check_cmd("after_rst", 0, 6'd17, 32'h20, 1'b1);
    check_cmd("after_rst", 3, 6'd24, 32'h21, 1'b0);
    check("after_rst_blk", cap_blk, 2);
    check("after_rst_err", cap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
